// File: rtl/pla_x7dn_result_fifo.sv
// x7dn PLA result stage: handshake capture, FWFT FIFO,
// optional back-to-back dedup and saturating debug counters.
module pla_x7dn_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15,
  parameter int DEDUP = 1,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           z_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           push_cnt,
  output logic [CNT_W-1:0]           dup_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_push_cnt;
  logic [CNT_W-1:0] r_dup_cnt;
  logic             r_last_valid;
  logic [WIDTH-1:0] r_last_value;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_dup;
  logic w_write;
  logic w_pop;

  assign w_full   = (r_level == L_FULL);
  assign w_empty  = (r_level == '0);
  assign w_accept = in_valid & ~w_full;
  assign w_dup    = (DEDUP != 0) & r_last_valid
                  & (z_in == r_last_value);
  assign w_write  = w_accept & ~w_dup & ~flush;
  assign w_pop    = ~w_empty & out_ready & ~flush;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0
                   : r_mem[r_rd_ptr[AW-1:0]];
  assign level     = r_level;
  assign push_cnt  = r_push_cnt;
  assign dup_cnt   = r_dup_cnt;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr[AW-1:0]] <= z_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_write & ~w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop & ~w_write) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_valid <= 1'b0;
      r_last_value <= '0;
    end else if (flush) begin
      r_last_valid <= 1'b0;
    end else if (w_accept) begin
      r_last_valid <= 1'b1;
      r_last_value <= z_in;
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_push_cnt <= '0;
      r_dup_cnt  <= '0;
    end else if (!flush && w_accept) begin
      if (w_dup) begin
        if (r_dup_cnt != '1) begin
          r_dup_cnt <= r_dup_cnt + 1'b1;
        end
      end else if (r_push_cnt != '1) begin
        r_push_cnt <= r_push_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pla_x7dn_result_fifo.sv
// Bench: two configurations (dedup/8-bit, no-dedup/4-bit)
// driven together and checked against a list-based model.
module tb_pla_x7dn_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] z_in = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid;
  logic [14:0] a_out_data;
  logic [2:0]  a_level;
  logic [7:0]  a_push, a_dup;

  logic        b_in_ready, b_out_valid;
  logic [14:0] b_out_data;
  logic [2:0]  b_level;
  logic [3:0]  b_push, b_dup;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pla_x7dn_result_fifo #(
    .DEPTH(4), .WIDTH(15), .DEDUP(1), .CNT_W(8)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .z_in(z_in),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .flush(flush), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .level(a_level), .push_cnt(a_push),
    .dup_cnt(a_dup)
  );

  pla_x7dn_result_fifo #(
    .DEPTH(4), .WIDTH(15), .DEDUP(0), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .z_in(z_in),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .flush(flush), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .level(b_level), .push_cnt(b_push),
    .dup_cnt(b_dup)
  );

  // Model: an ordered list per configuration.
  logic [14:0] m_q [2][4];
  int          m_n [2];
  int          m_pc [2];
  int          m_dc [2];
  bit          m_lv [2];
  logic [14:0] m_lval [2];
  int          ded [2] = '{1, 0};
  int          cmax [2] = '{255, 15};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_n[k] = 0; m_pc[k] = 0; m_dc[k] = 0;
        m_lv[k] = 0; m_lval[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit acc, pop, dup;
        acc = in_valid && (m_n[k] < 4);
        pop = out_ready && (m_n[k] > 0);
        dup = (ded[k] != 0) && m_lv[k]
              && (z_in == m_lval[k]);
        if (flush) begin
          m_n[k] = 0;
          m_lv[k] = 0;
        end else begin
          if (pop) begin
            for (int j = 0; j < 3; j++)
              m_q[k][j] = m_q[k][j+1];
            m_n[k] = m_n[k] - 1;
          end
          if (acc) begin
            m_lval[k] = z_in;
            m_lv[k] = 1;
            if (dup) begin
              if (m_dc[k] < cmax[k]) m_dc[k]++;
            end else begin
              m_q[k][m_n[k]] = z_in;
              m_n[k] = m_n[k] + 1;
              if (m_pc[k] < cmax[k]) m_pc[k]++;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("A.out_valid", 32'(a_out_valid), 32'(m_n[0] > 0));
    chk("A.out_data", 32'(a_out_data),
        m_n[0] > 0 ? 32'(m_q[0][0]) : 32'd0);
    chk("A.level", 32'(a_level), 32'(m_n[0]));
    chk("A.in_ready", 32'(a_in_ready), 32'(m_n[0] != 4));
    chk("A.push_cnt", 32'(a_push), 32'(m_pc[0]));
    chk("A.dup_cnt", 32'(a_dup), 32'(m_dc[0]));
    chk("B.out_valid", 32'(b_out_valid), 32'(m_n[1] > 0));
    chk("B.out_data", 32'(b_out_data),
        m_n[1] > 0 ? 32'(m_q[1][0]) : 32'd0);
    chk("B.level", 32'(b_level), 32'(m_n[1]));
    chk("B.in_ready", 32'(b_in_ready), 32'(m_n[1] != 4));
    chk("B.push_cnt", 32'(b_push), 32'(m_pc[1]));
    chk("B.dup_cnt", 32'(b_dup), 32'(m_dc[1]));
  end

  task automatic step(input logic v, input logic [14:0] z,
                      input logic ordy, input logic fl);
    in_valid = v;
    z_in = z;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; flush = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst.out_valid", 32'(a_out_valid), 32'd0);
    chk("rst.out_data", 32'(a_out_data), 32'd0);
    chk("rst.level", 32'(a_level), 32'd0);
    chk("rst.in_ready", 32'(a_in_ready), 32'd1);
    chk("rst.push_cnt", 32'(a_push), 32'd0);

    step(1, 15'h1234, 0, 0);
    chk("push1.valid", 32'(a_out_valid), 32'd1);
    chk("push1.data", 32'(a_out_data), 32'h1234);
    chk("push1.level", 32'(a_level), 32'd1);
    chk("push1.cnt", 32'(a_push), 32'd1);
    step(0, 15'h0, 0, 1);

    for (int i = 1; i <= 4; i++) step(1, 15'(i), 0, 0);
    chk("full.level", 32'(b_level), 32'd4);
    chk("full.ready", 32'(b_in_ready), 32'd0);
    chk("full.head", 32'(b_out_data), 32'h1);
    step(1, 15'h5, 1, 0);
    chk("fullpop.head", 32'(b_out_data), 32'h2);
    chk("fullpop.level", 32'(b_level), 32'd3);
    chk("fullpop.ready", 32'(b_in_ready), 32'd1);
    chk("fullpop.cnt", 32'(a_push), 32'd5);
    step(1, 15'h5, 1, 0);
    chk("after.head", 32'(b_out_data), 32'h3);
    repeat (3) step(0, 15'h0, 1, 0);
    chk("drain.level", 32'(b_level), 32'd0);

    do_reset();
    step(1, 15'h7FFF, 0, 0);
    step(1, 15'h7FFF, 0, 0);
    step(1, 15'h0000, 0, 0);
    step(1, 15'h7FFF, 0, 0);
    chk("dedup.level", 32'(a_level), 32'd3);
    chk("dedup.push", 32'(a_push), 32'd3);
    chk("dedup.dup", 32'(a_dup), 32'd1);
    chk("nodedup.level", 32'(b_level), 32'd4);
    chk("dedup.head0", 32'(a_out_data), 32'h7FFF);
    step(0, 15'h0, 1, 0);
    chk("dedup.head1", 32'(a_out_data), 32'h0000);
    chk("dedup.lvl2", 32'(a_level), 32'd2);
    step(1, 15'h0123, 1, 0);
    chk("simul.level", 32'(a_level), 32'd2);
    chk("simul.head", 32'(a_out_data), 32'h7FFF);
    step(0, 15'h0, 1, 0);
    chk("simul.order", 32'(a_out_data), 32'h0123);
    repeat (4) step(0, 15'h0, 1, 0);

    do_reset();
    step(1, 15'h0001, 0, 0);
    step(1, 15'h0002, 0, 0);
    step(1, 15'h0AAA, 0, 0);
    chk("preflush.level", 32'(a_level), 32'd3);
    step(1, 15'h0AAA, 1, 1);
    chk("flush.level", 32'(a_level), 32'd0);
    chk("flush.valid", 32'(a_out_valid), 32'd0);
    chk("flush.data", 32'(a_out_data), 32'd0);
    chk("flush.push", 32'(a_push), 32'd3);
    step(1, 15'h0AAA, 0, 0);
    chk("postflush.level", 32'(a_level), 32'd1);
    chk("postflush.data", 32'(a_out_data), 32'h0AAA);
    chk("postflush.push", 32'(a_push), 32'd4);

    for (int i = 0; i < 20; i++)
      step(1, 15'(16'h0100 + i), 1, 0);
    chk("sat.b_push", 32'(b_push), 32'd15);
    chk("sat.a_push", 32'(a_push), 32'd24);
    chk("sat.a_valid", 32'(a_out_valid), 32'd1);

    in_valid = 0; out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst.valid", 32'(a_out_valid), 32'd0);
    chk("arst.data", 32'(a_out_data), 32'd0);
    chk("arst.level", 32'(a_level), 32'd0);
    chk("arst.ready", 32'(a_in_ready), 32'd1);
    chk("arst.a_push", 32'(a_push), 32'd0);
    chk("arst.b_push", 32'(b_push), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) step(0, 15'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
